ex_muldiv_seq: RTL and testbench

Iterative sequencer for RV32M multiply/divide operations, attached beside the single-cycle execute-stage ALU. It accepts one M-extension operation at a time, holds the pipeline stalled while a shift-add multiply or restoring divide runs over 32 iterations, and returns the result with its destination register tag. The ALU keeps all base-ISA operations; this block owns every operation with funct7 = 0000001.

---
 rtl/ex_muldiv_seq.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the execute-stage ALU.
// Shift-add multiply or restoring divide over 32 iterations, fixed 34-cycle latency.
module ex_muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd_q;
  logic [31:0] a_raw_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        div0_q;
  logic        ovf_q;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic signed [31:0] op_a_s;
  logic signed [31:0] op_b_s;
  logic               sign_a_en;
  logic               sign_b_en;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;

  assign op_a_s = op_a_i;
  assign op_b_s = op_b_i;

  always_comb begin
    sign_a_en = 1'b0;
    sign_b_en = 1'b0;
    case (op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a_en = 1'b1;
        sign_b_en = 1'b1;
      end
      3'b010:  sign_a_en = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sign_a_en & (op_a_s < 0);
  assign b_neg = sign_b_en & (op_b_s < 0);
  assign a_mag = cond_neg32(op_a_i, a_neg);
  assign b_mag = cond_neg32(op_b_i, b_neg);

  // Iteration datapath: acc = {hi, lo}; multiply keeps multiplier in lo,
  // divide keeps remainder in hi and dividend/quotient in lo.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;

  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  // Sign correction and special-case override
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_res;

  always_comb begin
    prod    = cond_neg64(acc, neg_q_q);
    quo     = cond_neg32(acc[31:0], neg_q_q);
    rem     = cond_neg32(acc[63:32], neg_r_q);
    fix_res = 32'd0;
    case (op_q)
      3'b000:                 fix_res = prod[31:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
      3'b100, 3'b101:         fix_res = div0_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo);
      default:                fix_res = div0_q ? a_raw_q : (ovf_q ? 32'd0 : rem);
    endcase
  end

  assign stall_o = ((state == IDLE) & start_i & ~flush_i) | (state == CALC) | (state == FIX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= 32'd0;
      rd_o     <= 5'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_q    <= op_i;
            rd_q    <= rd_i;
            a_raw_q <= op_a_i;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            div0_q  <= (op_b_i == 32'd0);
            ovf_q   <= ~op_i[0] & (op_a_i == 32'h8000_0000) & (op_b_i == 32'hFFFF_FFFF);
            opnd_q  <= op_i[2] ? b_mag : a_mag;
            acc     <= {32'd0, op_i[2] ? a_mag : b_mag};
            cnt     <= 5'd0;
            busy_o  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (flush_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            if (!op_q[2]) begin
              acc <= {mul_sum, acc[31:1]};
            end else if (!div_diff[33]) begin
              acc <= {div_diff[31:0], acc[30:0], 1'b1};
            end else begin
              acc <= {div_shift[31:0], acc[30:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (flush_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            result_o <= fix_res;
            rd_o     <= rd_q;
            done_o   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed vectors and corner sequences for the RV32M multiply/divide sequencer.
module tb_ex_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  ex_muldiv_seq dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .rd_i    (rd_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o),
    .rd_o    (rd_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_res = 32'd0;
  logic [4:0]  model_rd  = 5'd0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          glitch_k;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue at the current negedge; abort_kind 0 = none, 1 = flush, 2 = reset at abort_k.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int glitch_k,
                        input int abort_k, input int abort_kind, input string name);
    int bad_stall, bad_busy, bad_done, last;
    bad_stall = 0;
    bad_busy  = 0;
    bad_done  = 0;
    start_i = 1'b1;
    op_i    = op;
    op_a_i  = a;
    op_b_i  = b;
    rd_i    = rd;
    #1;
    if (stall_o !== 1'b1) bad_stall++;
    last = (abort_kind != 0) ? abort_k : 34;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      if (stall_o !== (k <= 33)) bad_stall++;
      if (busy_o !== 1'b1) bad_busy++;
      if (done_o !== (k == 34)) bad_done++;
      if (k == glitch_k) begin
        start_i = 1'b1;
        op_i    = MUL;
        op_a_i  = 32'd3;
        op_b_i  = 32'd3;
        rd_i    = rd ^ 5'h1f;
      end
      if (k == abort_k && abort_kind == 1) flush_i = 1'b1;
      if (k == abort_k && abort_kind == 2) rst_i = 1'b1;
    end
    check({name, " stall"}, bad_stall, 0);
    check({name, " busy"}, bad_busy, 0);
    check({name, " done"}, bad_done, 0);
    if (abort_kind == 0) begin
      check({name, " result"}, result_o, exp);
      check({name, " rd"}, {27'd0, rd_o}, {27'd0, rd});
      model_res = exp;
      model_rd  = rd;
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    rst_i   = 1'b0;
    start_i = 1'b0;
    check({name, " after done_o"}, {31'd0, done_o}, 32'd0);
    check({name, " after busy_o"}, {31'd0, busy_o}, 32'd0);
    check({name, " after stall_o"}, {31'd0, stall_o}, 32'd0);
    if (abort_kind == 2) begin
      model_res = 32'd0;
      model_rd  = 5'd0;
    end
    if (abort_kind != 0) begin
      check({name, " kept result"}, result_o, model_res);
      check({name, " kept rd"}, {27'd0, rd_o}, {27'd0, model_rd});
    end
  endtask

  initial begin
    vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0};
    vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 0};
    vecs[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 0};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 0};
    vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 0};
    vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 0};
    vecs[6]  = '{DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        5};
    vecs[7]  = '{REMU,   32'd100,        32'd7,         5'd12, 32'd2,         0};
    vecs[8]  = '{DIVU,   32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 0};
    vecs[9]  = '{REMU,   32'd5,          32'd0,         5'd14, 32'd5,         0};
    vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0};
    vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         0};
    vecs[12] = '{DIV,    32'hFFFF_FFFB,  32'd0,         5'd17, 32'hFFFF_FFFF, 0};
    vecs[13] = '{REM,    32'hFFFF_FFFB,  32'd0,         5'd18, 32'hFFFF_FFFB, 0};
    vecs[14] = '{MUL,    32'h1234_5678,  32'h10,        5'd19, 32'h2345_6780, 0};
    vecs[15] = '{DIV,    32'd7,          32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD, 0};
    vecs[16] = '{REM,    32'd7,          32'hFFFF_FFFE, 5'd21, 32'd1,         0};
    vecs[17] = '{MULH,   32'hFFFF_FFFF,  32'd1,         5'd22, 32'hFFFF_FFFF, 0};

    rst_i   = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 3'b000;
    op_a_i  = 32'd0;
    op_b_i  = 32'd0;
    rd_i    = 5'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset stall_o", {31'd0, stall_o}, 32'd0);
    check("reset busy_o", {31'd0, busy_o}, 32'd0);
    check("reset done_o", {31'd0, done_o}, 32'd0);
    check("reset result_o", result_o, 32'd0);
    check("reset rd_o", {27'd0, rd_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp,
             vecs[i].glitch_k, 0, 0, $sformatf("vec%0d", i));
    end

    // Flush at N+10, then a new op accepted at N+11 completing at N+45
    run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'd0, 0, 10, 1, "flush");
    run_op(DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 0, 0, 0, "post-flush");

    // Reset at N+20, then a normal op from IDLE
    run_op(DIV, 32'd1000, 32'd3, 5'd4, 32'd0, 0, 20, 2, "midreset");
    run_op(REM, 32'd1000, 32'd3, 5'd23, 32'd1, 0, 0, 0, "post-reset");

    // start_i and flush_i together in IDLE are not accepted
    begin
      int bad_done;
      bad_done = 0;
      start_i = 1'b1;
      flush_i = 1'b1;
      op_i    = MUL;
      op_a_i  = 32'd2;
      op_b_i  = 32'd2;
      rd_i    = 5'd1;
      #1;
      check("start+flush stall_o", {31'd0, stall_o}, 32'd0);
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      check("start+flush busy_o", {31'd0, busy_o}, 32'd0);
      for (int k = 0; k < 36; k++) begin
        @(negedge clk_i);
        if (done_o !== 1'b0 || busy_o !== 1'b0) bad_done++;
      end
      check("start+flush no activity", bad_done, 0);
      check("start+flush result kept", result_o, model_res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
